// File: rtl/chess_pkg.sv
// Shared board geometry, direction codes, piece encoding and scanner states
// for the move-generator ray logic.
package chess_pkg;

  localparam logic [2:0] DIR_UP         = 3'd0;
  localparam logic [2:0] DIR_LEFT       = 3'd1;
  localparam logic [2:0] DIR_RIGHT      = 3'd2;
  localparam logic [2:0] DIR_DOWN       = 3'd3;
  localparam logic [2:0] DIR_UP_LEFT    = 3'd4;
  localparam logic [2:0] DIR_UP_RIGHT   = 3'd5;
  localparam logic [2:0] DIR_DOWN_LEFT  = 3'd6;
  localparam logic [2:0] DIR_DOWN_RIGHT = 3'd7;

  localparam logic [2:0] PT_NONE   = 3'd0;
  localparam logic [2:0] PT_PAWN   = 3'd1;
  localparam logic [2:0] PT_KNIGHT = 3'd2;
  localparam logic [2:0] PT_BISHOP = 3'd3;
  localparam logic [2:0] PT_ROOK   = 3'd4;
  localparam logic [2:0] PT_QUEEN  = 3'd5;
  localparam logic [2:0] PT_KING   = 3'd6;

  localparam int         COLOUR_BIT  = 3;
  localparam logic [3:0] PIECE_EMPTY = 4'h0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } scan_state_t;

  function automatic int pos_width(input int dim);
    return $clog2(dim * dim);
  endfunction

endpackage

// File: rtl/ray_step.sv
// One step of a ray walk: neighbouring square in the given direction and
// whether that step leaves the board (row/column arithmetic, no index wrap).
module ray_step
  import chess_pkg::*;
#(
  parameter  int BOARD_DIM = 8,
  localparam int POS_W     = pos_width(BOARD_DIM)
) (
  input  logic [POS_W-1:0] pos,
  input  logic [2:0]       direction,
  output logic [POS_W-1:0] next_pos,
  output logic             off_board
);

  int row, col, dr, dc, nr, nc;

  always_comb begin
    row = int'(pos) % BOARD_DIM;
    col = int'(pos) / BOARD_DIM;
    dr  = 0;
    dc  = 0;
    case (direction)
      DIR_UP:         begin dr = -1; dc =  0; end
      DIR_LEFT:       begin dr =  0; dc = -1; end
      DIR_RIGHT:      begin dr =  0; dc =  1; end
      DIR_DOWN:       begin dr =  1; dc =  0; end
      DIR_UP_LEFT:    begin dr = -1; dc = -1; end
      DIR_UP_RIGHT:   begin dr = -1; dc =  1; end
      DIR_DOWN_LEFT:  begin dr =  1; dc = -1; end
      default:        begin dr =  1; dc =  1; end
    endcase
    nr = row + dr;
    nc = col + dc;
    off_board = (nr < 0) || (nr >= BOARD_DIM) || (nc < 0) || (nc >= BOARD_DIM);
    next_pos  = off_board ? pos : POS_W'(nc * BOARD_DIM + nr);
  end

endmodule

// File: rtl/ray_scanner.sv
// Multi-cycle ray scanner: snapshots the board on start and walks one square
// per cycle until a piece, the board edge or the range limit is reached.
module ray_scanner
  import chess_pkg::*;
#(
  parameter  int BOARD_DIM = 8,
  parameter  int PIECE_W   = 4,
  parameter  int RANGE_W   = 3,
  localparam int POS_W     = pos_width(BOARD_DIM),
  localparam int NSQ       = BOARD_DIM * BOARD_DIM
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   ready,
  input  logic                   abort,
  input  logic [NSQ*PIECE_W-1:0] big_board,
  input  logic [POS_W-1:0]       current_pos,
  input  logic [2:0]             direction,
  input  logic [RANGE_W-1:0]     max_range,
  output logic                   done,
  output logic                   found,
  output logic [POS_W-1:0]       hit_pos,
  output logic [PIECE_W-1:0]     hit_piece,
  output logic [RANGE_W:0]       empty_steps,
  output logic [NSQ-1:0]         ray_mask
);

  scan_state_t state, state_n;

  logic [NSQ*PIECE_W-1:0] board_q;
  logic [2:0]             dir_q;
  logic [RANGE_W-1:0]     range_q;
  logic [POS_W-1:0]       cur_q;
  logic [PIECE_W-1:0]     squares [NSQ];

  logic [POS_W-1:0]   first_pos, la_pos;
  logic               first_off, la_off;
  logic [PIECE_W-1:0] sq;
  logic               occupied, range_hit, accept;

  for (genvar k = 0; k < NSQ; k++) begin : g_unpack
    assign squares[k] = board_q[k*PIECE_W +: PIECE_W];
  end

  // First step is judged from the live inputs at acceptance; afterwards the
  // square under examination is held in cur_q and the look-ahead is taken from it.
  ray_step #(.BOARD_DIM(BOARD_DIM)) u_step_first (
    .pos       (current_pos),
    .direction (direction),
    .next_pos  (first_pos),
    .off_board (first_off)
  );

  ray_step #(.BOARD_DIM(BOARD_DIM)) u_step_ahead (
    .pos       (cur_q),
    .direction (dir_q),
    .next_pos  (la_pos),
    .off_board (la_off)
  );

  assign sq        = squares[cur_q];
  assign occupied  = (sq[PIECE_W-2:0] != '0);
  assign range_hit = ((empty_steps + (RANGE_W+1)'(1)) == {1'b0, range_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          accept  = 1'b1;
          state_n = (first_off || max_range == '0) ? ST_DONE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (occupied || la_off || range_hit) state_n = ST_DONE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (abort) state_n = ST_IDLE;
  end

  assign ready = (state == ST_IDLE);
  assign done  = (state == ST_DONE) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board_q     <= '0;
      dir_q       <= '0;
      range_q     <= '0;
      cur_q       <= '0;
      found       <= 1'b0;
      hit_pos     <= '0;
      hit_piece   <= '0;
      empty_steps <= '0;
      ray_mask    <= '0;
    end else if (accept) begin
      board_q     <= big_board;
      dir_q       <= direction;
      range_q     <= max_range;
      cur_q       <= first_pos;
      found       <= 1'b0;
      hit_pos     <= current_pos;
      hit_piece   <= '0;
      empty_steps <= '0;
      ray_mask    <= '0;
    end else if (state == ST_SCAN && !abort) begin
      ray_mask <= ray_mask | (NSQ'(1) << cur_q);
      hit_pos  <= cur_q;
      cur_q    <= la_pos;
      if (occupied) begin
        found     <= 1'b1;
        hit_piece <= sq;
      end else begin
        empty_steps <= empty_steps + (RANGE_W+1)'(1);
      end
    end
  end

endmodule
